// File: rtl/sm_twi_dbg_slave.sv
// TWI (I2C) slave that lets an external master select a CPU debug register and read it back MSB-first.
// Optional feature: define SM_TWI_DBG_AUTOINC_EN to step regAddr after every fully ACKed word.
`timescale 1ns/1ps
module sm_twi_dbg_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h3C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        busy
);

  localparam int unsigned REG_W     = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned BYTE_CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t state, stateNxt;

  logic [SYNC_STAGES-1:0] sclSync, sdaSync;
  logic                   sclD, sdaD;
  logic                   sclS, sdaS;
  logic                   sclRise, sclFall, startDet, stopDet, busEvt;

  logic [BIT_CNT_W-1:0]  bitCnt;
  logic [BYTE_CNT_W-1:0] byteCnt, byteNxt;
  logic [BYTE_W-1:0]     shiftReg, rxNext;
  logic [DATA_W-1:0]     txWord, wordNxt;
  logic                  rw, ackPhase;
  logic                  addrHit, ackState, enterTx, newWord;
  logic                  sdaOeNxt, busyNxt;

  // Synchronizers reset low so a mid-bit reset release never fakes a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclSync <= '0;
      sdaSync <= '0;
      sclD    <= 1'b0;
      sdaD    <= 1'b0;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], scl_i};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], sda_i};
      sclD    <= sclS;
      sdaD    <= sdaS;
    end
  end

  assign sclS     = sclSync[SYNC_STAGES-1];
  assign sdaS     = sdaSync[SYNC_STAGES-1];
  assign sclRise  = sclS & ~sclD;
  assign sclFall  = ~sclS & sclD;
  assign startDet = sclS & sclD & ~sdaS & sdaD;
  assign stopDet  = sclS & sclD & sdaS & ~sdaD;
  assign busEvt   = startDet | stopDet;

  assign rxNext   = {shiftReg[BYTE_W-2:0], sdaS};
  assign addrHit  = (rxNext[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'd0);
  assign ackState = (state == ADDR_ACK) || (state == REG_ACK) || (state == TX_ACK);

  // Start of a transmitted byte: first byte after the address or after a master ACK.
  always_comb begin
    newWord = (state == ADDR_ACK) || (byteCnt == 2'd3);
    enterTx = !busEvt && sclFall && ackPhase &&
              (((state == ADDR_ACK) && rw) || (state == TX_ACK));
    wordNxt = newWord ? regData : txWord;
    byteNxt = newWord ? '0 : byteCnt + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    if (stopDet)       stateNxt = IDLE;
    else if (startDet) stateNxt = ADDR;
    else begin
      unique case (state)
        IDLE:      stateNxt = IDLE;
        ADDR:      if (sclRise && bitCnt == 3'd7) stateNxt = addrHit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  if (sclFall && ackPhase) stateNxt = rw ? TX : REG;
        REG:       if (sclRise && bitCnt == 3'd7) stateNxt = REG_ACK;
        REG_ACK:   if (sclFall && ackPhase) stateNxt = WAIT_STOP;
        TX:        if (sclRise && bitCnt == 3'd7) stateNxt = TX_ACK;
        TX_ACK: begin
          if (sclRise && sdaS)          stateNxt = WAIT_STOP;
          else if (sclFall && ackPhase) stateNxt = TX;
        end
        WAIT_STOP: stateNxt = WAIT_STOP;
        default:   stateNxt = IDLE;
      endcase
    end
  end

  // SDA only moves on the synced SCL fall; ACK slots hold low across the 9th clock.
  always_comb begin
    sdaOeNxt = sda_oe;
    busyNxt  = !((stateNxt == IDLE) || (stateNxt == ADDR));
    if (busEvt)       sdaOeNxt = 1'b0;
    else if (enterTx) sdaOeNxt = ~wordNxt[~{byteNxt, 3'b000}];
    else if (sclFall) begin
      unique case (state)
        ADDR_ACK, REG_ACK: sdaOeNxt = ~ackPhase;
        TX:                sdaOeNxt = ~txWord[~{byteCnt, bitCnt}];
        default:           sdaOeNxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      regAddr  <= '0;
      bitCnt   <= '0;
      byteCnt  <= '0;
      shiftReg <= '0;
      txWord   <= '0;
      rw       <= 1'b0;
      ackPhase <= 1'b0;
    end else begin
      sda_oe <= sdaOeNxt;
      busy   <= busyNxt;

      if (stateNxt != state) ackPhase <= 1'b0;
      else if (sclRise && ackState && !((state == TX_ACK) && sdaS)) ackPhase <= 1'b1;

      if (busEvt) begin
        bitCnt  <= '0;
        byteCnt <= '0;
      end else begin
        if (sclRise && ((state == ADDR) || (state == REG) || (state == TX)))
          bitCnt <= bitCnt + 3'd1;
        if (enterTx) byteCnt <= byteNxt;
        if (sclRise && ((state == ADDR) || (state == REG))) shiftReg <= rxNext;
        if (sclRise && (state == ADDR) && (bitCnt == 3'd7)) rw <= rxNext[0];
        if (enterTx && newWord) txWord <= regData;
        if (sclRise && (state == REG) && (bitCnt == 3'd7))
          regAddr <= rxNext[REG_W-1:0];
`ifdef SM_TWI_DBG_AUTOINC_EN
        else if (sclRise && (state == TX_ACK) && !sdaS && (byteCnt == 2'd3))
          regAddr <= regAddr + 5'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sm_twi_dbg_slave.sv
// Randomized bench for sm_twi_dbg_slave: a bit-banged TWI master against a transaction-level model.
`timescale 1ns/1ps
module tb_sm_twi_dbg_slave;

  localparam logic [6:0] SLV = 7'h3C;
  localparam int Q = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        mSda = 1'b0;
  logic        sda_oe, busy;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        sdaLine;
  logic [31:0] regFile [32];
  logic [4:0]  mAddr;
  int          nVec = 0;
  int          nErr = 0;
  int          oeCnt = 0;

  assign sdaLine = mSda & ~sda_oe;
  assign regData = regFile[regAddr];

  sm_twi_dbg_slave dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sdaLine),
    .sda_oe(sda_oe), .regAddr(regAddr), .regData(regData), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (sda_oe) oeCnt <= oeCnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clkBit(input logic b, output logic r);
    #Q mSda = b;
    #Q scl = 1'b1;
    #Q r = sdaLine;
    #Q scl = 1'b0;
  endtask

  task automatic startC();
    mSda = 1'b1;
    #Q scl = 1'b1;
    #Q mSda = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic stopC();
    #Q mSda = 1'b0;
    #Q scl = 1'b1;
    #Q mSda = 1'b1;
    #Q;
  endtask

  task automatic wrByte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clkBit(d[i], r);
    clkBit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rdByte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clkBit(1'b1, r);
      d[i] = r;
    end
    clkBit(nack, r);
  endtask

  // Write transaction: address ACK only on a match; only the first data byte is ACKed.
  task automatic doWrite(input logic [6:0] a, input logic [7:0] d, input int extra, input bit doStop);
    logic ack;
    logic hit;
    hit = (a == SLV);
    startC();
    wrByte({a, 1'b0}, ack);
    chk("addr ack", 32'(ack), 32'(hit));
    wrByte(d, ack);
    chk("reg ack", 32'(ack), 32'(hit));
    if (hit) mAddr = d[4:0];
    for (int i = 0; i < extra; i++) begin
      wrByte(8'($urandom), ack);
      chk("extra nack", 32'(ack), 32'd0);
    end
    chk("regAddr after write", 32'(regAddr), 32'(mAddr));
    if (doStop) begin
      stopC();
      chk("busy after stop", 32'(busy), 32'd0);
    end
  endtask

  // Read transaction: each word is the register value seen at its first byte.
  task automatic doRead(input int n);
    logic        ack;
    logic [7:0]  d, e;
    logic [31:0] word;
    word = '0;
    startC();
    wrByte({SLV, 1'b1}, ack);
    chk("read addr ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 0) word = regFile[mAddr];
      rdByte(i == n - 1, d);
      e = 8'(word >> (8 * (3 - i % 4)));
      chk("read byte", 32'(d), 32'(e));
      if (i % 4 == 0) regFile[mAddr] = $urandom;
`ifdef SM_TWI_DBG_AUTOINC_EN
      if ((i % 4 == 3) && (i != n - 1)) mAddr = mAddr + 5'd1;
`endif
      chk("regAddr during read", 32'(regAddr), 32'(mAddr));
    end
    chk("sda released after nack", 32'(sda_oe), 32'd0);
    chk("busy before stop", 32'(busy), 32'd1);
    stopC();
    chk("busy after read", 32'(busy), 32'd0);
  endtask

  initial begin
    logic r;
    int   oeBefore;
    for (int i = 0; i < 32; i++) regFile[i] = $urandom;
    mAddr = '0;

    // Reset held mid-bit with SCL high and SDA low.
    #(4 * Q);
    chk("reset sda_oe", 32'(sda_oe), 32'd0);
    chk("reset regAddr", 32'(regAddr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #Q scl = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clkBit(1'($urandom), r);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle sda_oe", 32'(sda_oe), 32'd0);
    end
    stopC();

    doWrite(SLV, 8'h02, 0, 1'b1);
    chk("regAddr=2", 32'(regAddr), 32'd2);
    regFile[2] = 32'hDEADBEEF;
    doRead(4);

    doWrite(SLV, 8'h1F, 0, 1'b1);
    doRead(8);

    oeBefore = oeCnt;
    doWrite(7'h28, 8'h02, 0, 1'b1);
    chk("mismatch sda quiet", 32'(oeCnt - oeBefore), 32'd0);

    doWrite(SLV, 8'h05, 0, 1'b0);
    doRead(4);

    doWrite(SLV, 8'hE7, 2, 1'b1);

    // STOP in the middle of a register byte.
    startC();
    wrByte({SLV, 1'b0}, r);
    for (int i = 0; i < 3; i++) clkBit(1'($urandom), r);
    stopC();
    chk("midbyte stop busy", 32'(busy), 32'd0);
    chk("midbyte stop sda_oe", 32'(sda_oe), 32'd0);
    chk("midbyte stop regAddr", 32'(regAddr), 32'(mAddr));

    for (int t = 0; t < 8; t++) begin
      doWrite(($urandom % 3 == 0) ? 7'($urandom) : SLV, 8'($urandom), int'($urandom % 2), 1'b1);
      doRead(1 + int'($urandom % 9));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
